// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the seven-segment scan controller.
//   SEG_OFF    : all segments dark (active-low)
//   AN_OFF     : all anodes disabled, widest supported display; slice to DIGITS
//   GLYPH      : 16-entry hex glyph table, active-low {a,b,c,d,e,f,g}, entry k = hex k
//   glyph_of() : table lookup helper
package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Packed so that GLYPH[k] selects entry k; listed from F down to 0.
    localparam logic [15:0][6:0] GLYPH = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
        return GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
// Bundles the host-side load path and the board-side display pins.
//   host -> ctrl : value[4*DIGITS], dp[DIGITS], load, blank_lz, bright[4]
//   ctrl -> pins : led[7], dp_n, an[DIGITS]
//   ctrl -> host : pending, frame_done
// Handshake: load is a one-cycle strobe with no ready; it is accepted on every
// rising CLK edge it is high, and value/dp must be valid in that same cycle.
// pending tells the host a captured value has not reached the display yet;
// frame_done pulses once per frame when the display registers may change.
// Modports: master = host/board side, slave = the controller.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic                blank_lz;
    logic [3:0]          bright;
    logic [6:0]          led;
    logic                dp_n;
    logic [DIGITS-1:0]   an;
    logic                pending;
    logic                frame_done;

    modport master (
        output value, dp, load, blank_lz, bright,
        input  led, dp_n, an, pending, frame_done
    );

    modport slave (
        input  value, dp, load, blank_lz, bright,
        output led, dp_n, an, pending, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational hex-nibble to active-low segment decoder.
//   nibble : hex digit to show
//   blank  : 1 = force all segments off (leading-zero suppression)
//   seg    : {a,b,c,d,e,f,g}, active-low
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_OFF : glyph_of(nibble);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Multiplexed common-anode seven-segment scanner with shadowed value/dp,
// frame-boundary update, leading-zero blanking and 16-level PWM brightness.
//   CLK   : system clock
//   reset : synchronous, active-low
//   bus   : seg7_scan_ctrl_if.slave (value/dp/load/blank_lz/bright in,
//           led/dp_n/an/pending/frame_done out)
// Parameters: DIGITS (2..8) digits scanned, DIV_BITS = log2 cycles per slot.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 15
) (
    input  logic               CLK,
    input  logic               reset,
    seg7_scan_ctrl_if.slave    bus
);

    localparam int                IDX_W      = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];

    // Scan state
    logic [DIV_BITS-1:0] pre;
    logic [IDX_W-1:0]    idx;

    // Shadow (host-written) and display (shown) copies
    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] disp_value;
    logic [DIGITS-1:0]   disp_dp;
    logic                pending_q;
    logic                frame_done_q;

    // Registered pin drivers
    logic [6:0]          led_q;
    logic                dp_n_q;
    logic [DIGITS-1:0]   an_q;

    // Combinational helpers
    logic                tick;
    logic                boundary;
    logic [3:0]          phase;
    logic                lit;
    logic [3:0]          cur_nibble;
    logic [DIGITS-1:0]   zero_from;
    logic                blank_cur;
    logic [DIGITS-1:0]   an_sel;
    logic [6:0]          led_next;

    always_comb begin
        tick     = &pre;
        boundary = tick && (idx == '0);
        // PWM phase is the top nibble of the prescaler, so each slot is
        // divided into 16 equal sub-periods.
        phase    = pre[DIV_BITS-1 -: 4];
        lit      = (bus.bright == 4'hF) || (phase < bus.bright);
    end

    // zero_from[k] = every display nibble from the leftmost down to k is zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run          = run && (disp_value[4*k +: 4] == 4'h0);
            zero_from[k] = run;
        end
    end

    always_comb begin
        cur_nibble = disp_value[4*int'(idx) +: 4];
        // Digit 0 always shows, so a value of zero still reads "0".
        blank_cur  = bus.blank_lz && (idx != '0) && zero_from[idx];
        an_sel     = ~(DIGITS'(1) << idx);
    end

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .blank  (blank_cur),
        .seg    (led_next)
    );

    // Prescaler and slot index; idx counts down so the leftmost digit is
    // scanned first and idx==0 ends the frame.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            pre <= '0;
            idx <= IDX_LAST;
        end else begin
            pre <= pre + DIV_BITS'(1);
            if (tick) begin
                idx <= (idx == '0) ? IDX_LAST : idx - IDX_W'(1);
            end
        end
    end

    // Shadow/display transfer. A load landing on the boundary cycle bypasses
    // the shadow wait and goes straight to the display, so pending never rises.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            disp_value   <= '0;
            disp_dp      <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_value <= bus.value;
                shadow_dp    <= bus.dp;
            end
            if (boundary) begin
                if (bus.load) begin
                    disp_value <= bus.value;
                    disp_dp    <= bus.dp;
                end else if (pending_q) begin
                    disp_value <= shadow_value;
                    disp_dp    <= shadow_dp;
                end
                pending_q <= 1'b0;
            end else if (bus.load) begin
                pending_q <= 1'b1;
            end
            frame_done_q <= boundary;
        end
    end

    // Pin registers. an is derived from a single idx, so at most one anode
    // is ever low, including across slot changes.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            led_q  <= SEG_OFF;
            dp_n_q <= 1'b1;
            an_q   <= AN_ALL_OFF;
        end else begin
            led_q  <= led_next;
            dp_n_q <= ~disp_dp[idx];
            an_q   <= lit ? an_sel : AN_ALL_OFF;
        end
    end

    assign bus.led        = led_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an         = an_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule
